// File: rtl/window_gen.sv
// Raster-to-window converter: turns a stream of per-pixel mask bits into an
// N_SIZE x N_SIZE zero-padded neighbourhood per pixel, with an end-of-frame flush.
module window_gen #(
    parameter int N_SIZE = 5,
    parameter int COLORS = 1,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic                                      in_sof,
    input  logic [COLORS-1:0]                         in_pix,
    output logic                                      in_ready,
    output logic                                      out_valid,
    output logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] out_win,
    output logic [$clog2(IMG_W)-1:0]                  out_x,
    output logic [$clog2(IMG_H)-1:0]                  out_y
);
    localparam int R  = N_SIZE / 2;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int D  = R * IMG_W + R;
    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
    localparam logic [XW-1:0] XFill = XW'(R - 1);
    localparam logic [YW-1:0] YFill = YW'(R);

    typedef enum logic [1:0] {StFill, StRun, StFlush} state_t;

    state_t                                    r_state;
    logic                                      r_in_ready;
    logic                                      r_out_valid;
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] r_out_win;
    logic [XW-1:0]                             r_out_x;
    logic [YW-1:0]                             r_out_y;
    logic [XW-1:0]                             r_xi;
    logic [XW-1:0]                             r_xo;
    logic [YW-1:0]                             r_yi;
    logic [YW-1:0]                             r_yo;
    logic [COLORS-1:0]                         r_lb [0:N_SIZE-2][0:IMG_W-1];
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] r_win;

    logic                                      w_flush;
    logic                                      w_accept;
    logic                                      w_sof;
    logic                                      w_shift;
    logic                                      w_emit;
    logic [COLORS-1:0]                         w_pix;
    logic [XW-1:0]                             w_xe;
    logic [YW-1:0]                             w_ye;
    logic [XW-1:0]                             w_xn;
    logic [YW-1:0]                             w_yn;
    logic [XW-1:0]                             w_xon;
    logic [YW-1:0]                             w_yon;
    logic                                      w_last_in;
    logic                                      w_last_out;
    logic [0:N_SIZE-1][COLORS-1:0]             w_col;
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] w_win_next;
    logic [0:N_SIZE-1][0:N_SIZE-1][COLORS-1:0] w_win_mask;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_win   = r_out_win;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;

    assign w_flush  = (r_state == StFlush);
    assign w_accept = in_valid & r_in_ready;
    assign w_sof    = w_accept & in_sof;
    assign w_shift  = w_accept | w_flush;
    assign w_emit   = w_flush | (w_accept & ~in_sof & (r_state == StRun));
    assign w_pix    = w_flush ? '0 : in_pix;

    // A start-of-frame beat is pixel (0,0) regardless of where the counters stand.
    assign w_xe = w_sof ? '0 : r_xi;
    assign w_ye = w_sof ? '0 : r_yi;
    assign w_xn = (w_xe == XLast) ? '0 : w_xe + 1'b1;
    assign w_yn = (w_xe != XLast) ? w_ye : ((w_ye == YLast) ? '0 : w_ye + 1'b1);
    assign w_xon = (r_xo == XLast) ? '0 : r_xo + 1'b1;
    assign w_yon = (r_xo != XLast) ? r_yo : ((r_yo == YLast) ? '0 : r_yo + 1'b1);
    assign w_last_in  = (w_xe == XLast) && (w_ye == YLast);
    assign w_last_out = (r_xo == XLast) && (r_yo == YLast);

    always_comb begin
        w_col = '0;
        w_col[N_SIZE-1] = w_pix;
        for (int k = 0; k < N_SIZE - 1; k++) begin
            w_col[N_SIZE-2-k] = r_lb[k][w_xe];
        end
        w_win_next = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE - 1; j++) begin
                w_win_next[i][j] = r_win[i][j+1];
            end
            w_win_next[i][N_SIZE-1] = w_col[i];
        end
    end

    // Stale line-buffer and wrapped-row contents are hidden here, not by clearing.
    always_comb begin
        int cx;
        int cy;
        cx = 0;
        cy = 0;
        w_win_mask = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE; j++) begin
                cx = int'(r_xo) + j - R;
                cy = int'(r_yo) + i - R;
                if (cx >= 0 && cx < IMG_W && cy >= 0 && cy < IMG_H) begin
                    w_win_mask[i][j] = w_win_next[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb[0][w_xe] <= w_pix;
            for (int k = 0; k < N_SIZE - 2; k++) begin
                r_lb[k+1][w_xe] <= r_lb[k][w_xe];
            end
            r_win <= w_win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StFill;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_xi        <= '0;
            r_yi        <= '0;
            r_xo        <= '0;
            r_yo        <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_win <= w_win_mask;
                r_out_x   <= r_xo;
                r_out_y   <= r_yo;
                r_xo      <= w_xon;
                r_yo      <= w_yon;
            end
            if (w_shift) begin
                r_xi <= w_xn;
                r_yi <= w_yn;
            end
            if (w_sof) begin
                r_state <= StFill;
                r_xo    <= '0;
                r_yo    <= '0;
            end else begin
                case (r_state)
                    StFill: begin
                        if (w_accept && w_xe == XFill && w_ye == YFill) r_state <= StRun;
                    end
                    StRun: begin
                        if (w_accept && w_last_in) begin
                            r_state    <= StFlush;
                            r_in_ready <= 1'b0;
                        end
                    end
                    StFlush: begin
                        if (w_last_out) begin
                            r_state    <= StFill;
                            r_in_ready <= 1'b1;
                            r_xi       <= '0;
                            r_yi       <= '0;
                            r_xo       <= '0;
                            r_yo       <= '0;
                        end
                    end
                    default: r_state <= StFill;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (D < IMG_W * IMG_H && N_SIZE >= 3 && (N_SIZE % 2) == 1);
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen (3x3 window, 8x4 frame): a cycle monitor predicts
// out_valid/in_ready and checks every window against a direct 2-D image model.
module tb_window_gen;
    localparam int W = 8;
    localparam int H = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_sof;
    logic [0:0]           in_pix;
    logic                 in_ready;
    logic                 out_valid;
    logic [0:2][0:2][0:0] out_win;
    logic [2:0]           out_x;
    logic [1:0]           out_y;

    always #5 clk = ~clk;

    window_gen #(
        .N_SIZE(3),
        .COLORS(1),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_pix   (in_pix),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_win  (out_win),
        .out_x    (out_x),
        .out_y    (out_y)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic       img     [0:W*H-1];
    logic [8:0] cap     [0:W*H-1];
    logic [8:0] ref_cap [0:W*H-1];
    bit         armed = 0;
    bit         exp_ov = 0;
    int         acc = 0;
    int         fl = 0;
    int         ex = 0;
    int         ey = 0;
    int         frm_out = 0;
    int         first_acc = 0;
    int         last_x = 0;
    int         last_y = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_win(input int x, input int y);
        logic [8:0] w;
        int cx;
        int cy;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                cx = x - 1 + j;
                cy = y - 1 + i;
                if (cx >= 0 && cx < W && cy >= 0 && cy < H) w[8-(i*3+j)] = img[cy*W+cx];
            end
        end
        return w;
    endfunction

    // Monitor: checks this cycle against last cycle's prediction, then predicts the next.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check_eq("out_valid", out_valid, exp_ov);
                check_eq("in_ready", in_ready, fl == 0);
                if (out_valid) begin
                    check_eq($sformatf("out_x#%0d", frm_out), out_x, ex);
                    check_eq($sformatf("out_y#%0d", frm_out), out_y, ey);
                    check_eq($sformatf("win(%0d,%0d)", ex, ey), out_win, model_win(ex, ey));
                    cap[ey*W+ex] = out_win;
                    if (frm_out == 0) first_acc = acc;
                    frm_out++;
                    last_x = out_x;
                    last_y = out_y;
                    ex++;
                    if (ex == W) begin
                        ex = 0;
                        ey = (ey + 1) % H;
                    end
                end
            end
            if (reset) begin
                exp_ov = 0; acc = 0; fl = 0; ex = 0; ey = 0; frm_out = 0;
            end else if (fl > 0) begin
                exp_ov = 1;
                fl--;
            end else if (in_valid) begin
                if (in_sof) begin
                    exp_ov = 0; acc = 1; ex = 0; ey = 0; frm_out = 0;
                end else begin
                    exp_ov = (acc >= 9);
                    acc++;
                    if (acc == W * H) fl = 9;
                end
            end else begin
                exp_ov = 0;
            end
        end
    end

    task automatic send_frame(input int nbeats, input int gap_pct);
        for (int k = 0; k < nbeats; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_pix   = img[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
    endtask

    task automatic wait_done(output int low_cycles);
        low_cycles = 0;
        while (!in_ready && low_cycles < 60) begin
            @(posedge clk); #1;
            low_cycles++;
        end
        if (!in_ready) check_eq("flush_timeout", 0, 1);
        @(negedge clk); #1;
    endtask

    task automatic clear_cap();
        for (int k = 0; k < W * H; k++) cap[k] = 9'h155;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pix   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_win", out_win, 0);
        check_eq("rst_out_x", out_x, 0);
        check_eq("rst_out_y", out_y, 0);
        armed = 1;

        // All-ones frame, continuous valid
        for (int k = 0; k < W * H; k++) img[k] = 1'b1;
        clear_cap();
        send_frame(W * H, 0);
        wait_done(lc);
        check_eq("ones_flush_cycles", lc, 9);
        check_eq("ones_first_acc", first_acc, 10);
        check_eq("ones_count", frm_out, 32);
        check_eq("ones_win00", cap[0], 9'h01B);
        check_eq("ones_win31", cap[1*W+3], 9'h1FF);
        check_eq("ones_last_x", last_x, 7);
        check_eq("ones_last_y", last_y, 3);
        repeat (2) @(posedge clk);
        #1;

        // Single one at (7,1)
        for (int k = 0; k < W * H; k++) img[k] = 1'b0;
        img[1*W+7] = 1'b1;
        clear_cap();
        send_frame(W * H, 0);
        wait_done(lc);
        check_eq("dot_count", frm_out, 32);
        check_eq("dot_win02", cap[2*W+0], 9'h000);
        check_eq("dot_win61", cap[1*W+6], 9'h008);
        check_eq("dot_win72", cap[2*W+7], 9'h080);
        for (int k = 0; k < W * H; k++) ref_cap[k] = cap[k];
        repeat (3) @(posedge clk);
        #1;

        // Same frame with ~50% valid gaps
        clear_cap();
        send_frame(W * H, 50);
        wait_done(lc);
        check_eq("gap_count", frm_out, 32);
        check_eq("gap_last_x", last_x, 7);
        check_eq("gap_last_y", last_y, 3);
        for (int k = 0; k < W * H; k++) check_eq($sformatf("gap_same%0d", k), cap[k], ref_cap[k]);
        repeat (2) @(posedge clk);
        #1;

        // Frame restart: in_sof on the 12th beat
        for (int k = 0; k < W * H; k++) img[k] = 1'($urandom_range(1));
        send_frame(11, 0);
        send_frame(W * H, 0);
        wait_done(lc);
        check_eq("sof_first_acc", first_acc, 10);
        check_eq("sof_count", frm_out, 32);
        check_eq("sof_last_y", last_y, 3);
        repeat (2) @(posedge clk);
        #1;

        // Reset during the 4th flush cycle, then a clean frame
        for (int k = 0; k < W * H; k++) img[k] = 1'($urandom_range(1));
        send_frame(W * H, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("flrst_in_ready", in_ready, 1);
        check_eq("flrst_out_valid", out_valid, 0);
        for (int k = 0; k < W * H; k++) img[k] = 1'($urandom_range(1));
        send_frame(W * H, 25);
        wait_done(lc);
        check_eq("flrst_count", frm_out, 32);
        check_eq("flrst_last_x", last_x, 7);
        check_eq("flrst_last_y", last_y, 3);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
